// File: rtl/execute_m.sv
// execute_m: RV32I/RV32IM execute stage with valid/ready handshake.
// Single-cycle ALU/jump/branch/memory-address work completes in one edge;
// M-extension multiply and divide run behind a small busy state machine and
// present their result through the same registered output slot.
module execute_m #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 1,
    parameter int ENABLE_M   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    output logic            valid_ro,
    input  logic            ready_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] r0data_i,
    input  logic [XLEN-1:0] r1data_i,
    output logic [XLEN-1:0] pc_ro,
    output logic [31:0]     inst_ro,
    output logic [XLEN-1:0] r0data_ro,
    output logic [XLEN-1:0] r1data_ro,
    output logic [XLEN-1:0] result_ro,
    output logic            busy_o,
    output logic [XLEN-1:0] jumpaddr_o,
    output logic            jumptaken_o,
    output logic [XLEN-1:0] datamemaddr_o,
    output logic [XLEN-1:0] datamemdata_o,
    output logic            datamemwrite_o,
    output logic [1:0]      datamemwidth_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam int SH_W    = $clog2(XLEN);
    localparam int CNT_MAX = (MUL_CYCLES > XLEN) ? MUL_CYCLES : XLEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t state, state_n;
    logic [CNT_W-1:0] cnt;

    // Instruction fields and immediates
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic signed [XLEN-1:0] rs1_s, rs2_s;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign imm_i  = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign imm_s  = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b  = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                     inst_i[11:8], 1'b0};
    assign imm_j  = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                     inst_i[30:21], 1'b0};
    assign imm_u  = {inst_i[31:12], 12'b0};
    assign rs1_s  = r0data_i;
    assign rs2_s  = r1data_i;

    // Integer ALU shared by OP and OP-IMM; shifts use the low SH_W bits of b
    function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic sub,
                                            input logic arith,
                                            input logic signed [XLEN-1:0] a,
                                            input logic signed [XLEN-1:0] b);
        logic [SH_W-1:0] sh;
        sh = b[SH_W-1:0];
        case (f3)
            3'b000:  alu = sub ? (a - b) : (a + b);
            3'b001:  alu = a << sh;
            3'b010:  alu = {{(XLEN-1){1'b0}}, (a < b)};
            3'b011:  alu = {{(XLEN-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
            3'b100:  alu = a ^ b;
            3'b101: begin
                if (arith) alu = a >>> sh;
                else       alu = $unsigned(a) >> sh;
            end
            3'b110:  alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    // Branch condition for funct3; reserved encodings never branch
    function automatic logic br_taken(input logic [2:0] f3,
                                      input logic signed [XLEN-1:0] a,
                                      input logic signed [XLEN-1:0] b);
        case (f3)
            3'b000:  br_taken = (a == b);
            3'b001:  br_taken = (a != b);
            3'b100:  br_taken = (a < b);
            3'b101:  br_taken = (a >= b);
            3'b110:  br_taken = ($unsigned(a) < $unsigned(b));
            3'b111:  br_taken = ($unsigned(a) >= $unsigned(b));
            default: br_taken = 1'b0;
        endcase
    endfunction

    logic is_m_op, accept;

    assign is_m_op = (ENABLE_M != 0) && (opcode == OPC_OP) && (funct7 == F7_MULDIV);
    assign busy_o  = (state != S_IDLE);
    assign ready_o = (state == S_IDLE) && (!valid_ro || ready_i);
    assign accept  = valid_i && ready_o && !flush_i;

    logic [XLEN-1:0] res_single;

    // Single-cycle result; unknown opcodes (and M-ops when disabled) give all-ones
    always_comb begin
        res_single = '1;
        case (opcode)
            OPC_OP:    if (funct7 != F7_MULDIV)
                           res_single = alu(funct3, funct7[5], funct7[5], rs1_s, rs2_s);
            OPC_OPIMM: res_single = alu(funct3, 1'b0, funct7[5], rs1_s, imm_i);
            OPC_LUI:   res_single = imm_u;
            OPC_AUIPC: res_single = pc_i + imm_u;
            OPC_JAL,
            OPC_JALR:  res_single = pc_i + XLEN'(4);
            default:   ;
        endcase
    end

    logic [XLEN-1:0] jalr_sum;
    logic            jump_cond;

    assign jalr_sum = rs1_s + imm_i;

    // Jump target and taken condition, decoded straight from the presented instruction
    always_comb begin
        jumpaddr_o = '1;
        jump_cond  = 1'b0;
        case (opcode)
            OPC_JAL: begin
                jumpaddr_o = pc_i + imm_j;
                jump_cond  = 1'b1;
            end
            OPC_JALR: begin
                jumpaddr_o = jalr_sum & ~XLEN'(1);
                jump_cond  = 1'b1;
            end
            OPC_BRANCH: begin
                jumpaddr_o = pc_i + imm_b;
                jump_cond  = br_taken(funct3, rs1_s, rs2_s);
            end
            default: ;
        endcase
    end

    // Data-memory request address for loads and stores
    always_comb begin
        datamemaddr_o = '0;
        if (opcode == OPC_LOAD)       datamemaddr_o = rs1_s + imm_i;
        else if (opcode == OPC_STORE) datamemaddr_o = rs1_s + imm_s;
    end

    assign jumptaken_o    = jump_cond && accept;
    assign datamemwrite_o = (opcode == OPC_STORE) && accept;
    assign datamemdata_o  = r1data_i;
    assign datamemwidth_o = funct3[1:0];

    // Latched M-op payload and operands
    logic [XLEN-1:0] pc_l, a_l, b_l;
    logic [31:0]     inst_l;
    logic [2:0]      f3_l;

    assign f3_l = inst_l[14:12];

    // Multiplier: sign- or zero-extend to 2*XLEN, keep the low 2*XLEN product bits
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic              mul_sa, mul_sb;

    assign mul_sa = (f3_l[1:0] == 2'b01) || (f3_l[1:0] == 2'b10);
    assign mul_sb = (f3_l[1:0] == 2'b01);
    assign mul_a  = {{XLEN{mul_sa & a_l[XLEN-1]}}, a_l};
    assign mul_b  = {{XLEN{mul_sb & b_l[XLEN-1]}}, b_l};
    assign prod   = mul_a * mul_b;

    // Restoring divider on magnitudes: quo starts as the dividend and fills with quotient bits
    logic [XLEN-1:0] quo, rem, dvs;
    logic            neg_q, neg_r, div_zero, div_ovf;
    logic [XLEN:0]   rem_sh;
    logic            rem_ge;
    logic [XLEN-1:0] rem_step, quo_step;

    assign rem_sh   = {rem, quo[XLEN-1]};
    assign rem_ge   = (rem_sh >= {1'b0, dvs});
    assign rem_step = rem_ge ? (rem_sh[XLEN-1:0] - dvs) : rem_sh[XLEN-1:0];
    assign quo_step = {quo[XLEN-2:0], rem_ge};

    logic            div_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    assign div_signed = !funct3[0];
    assign a_neg      = div_signed && r0data_i[XLEN-1];
    assign b_neg      = div_signed && r1data_i[XLEN-1];
    assign a_mag      = a_neg ? (-r0data_i) : r0data_i;
    assign b_mag      = b_neg ? (-r1data_i) : r1data_i;

    logic [XLEN-1:0] q_fin, r_fin, res_m;

    // Final M-op result, including divide-by-zero and signed-overflow overrides
    always_comb begin
        q_fin = neg_q ? (-quo) : quo;
        r_fin = neg_r ? (-rem) : rem;
        if (div_zero) begin
            q_fin = '1;
            r_fin = a_l;
        end else if (div_ovf) begin
            q_fin = a_l;
            r_fin = '0;
        end
        if (!f3_l[2]) res_m = (f3_l[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else          res_m = f3_l[1] ? r_fin : q_fin;
    end

    logic mul_last, div_last;

    assign mul_last = (cnt == CNT_W'(MUL_CYCLES - 1));
    assign div_last = (cnt == CNT_W'(XLEN - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // Next-state: M-op accept enters MUL/DIV; flush always returns to IDLE
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (accept && is_m_op) state_n = funct3[2] ? S_DIV : S_MUL;
            S_MUL:  if (mul_last) state_n = S_DONE;
            S_DIV:  if (div_last) state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
        if (flush_i) state_n = S_IDLE;
    end

    // Edge counter for the MUL and DIV states
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (flush_i || (state_n != state) ||
                     !((state == S_MUL) || (state == S_DIV))) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Operand/payload latch at M-op accept, then one divide iteration per DIV edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_l     <= '0;
            inst_l   <= '0;
            a_l      <= '0;
            b_l      <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else if (accept && is_m_op) begin
            pc_l     <= pc_i;
            inst_l   <= inst_i;
            a_l      <= r0data_i;
            b_l      <= r1data_i;
            quo      <= a_mag;
            rem      <= '0;
            dvs      <= b_mag;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (r1data_i == '0);
            div_ovf  <= div_signed && (r0data_i == MOST_NEG) && (r1data_i == '1);
        end else if (state == S_DIV) begin
            quo <= quo_step;
            rem <= rem_step;
        end
    end

    // Output slot: single-cycle ops load directly, M-ops load from DONE, consumed on ready_i
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_ro  <= 1'b0;
            pc_ro     <= '0;
            inst_ro   <= '0;
            r0data_ro <= '0;
            r1data_ro <= '0;
            result_ro <= '0;
        end else if (flush_i) begin
            valid_ro <= 1'b0;
        end else if (state == S_DONE) begin
            valid_ro  <= 1'b1;
            pc_ro     <= pc_l;
            inst_ro   <= inst_l;
            r0data_ro <= a_l;
            r1data_ro <= b_l;
            result_ro <= res_m;
        end else if (accept) begin
            if (is_m_op) begin
                valid_ro <= 1'b0;
            end else begin
                valid_ro  <= 1'b1;
                pc_ro     <= pc_i;
                inst_ro   <= inst_i;
                r0data_ro <= r0data_i;
                r1data_ro <= r1data_i;
                result_ro <= res_single;
            end
        end else if (ready_i) begin
            valid_ro <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_m.sv
// Directed bench for execute_m: a vector table for single-cycle ops plus
// hand-written multiply/divide, backpressure, flush and reset sequences.
module tb_execute_m;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [31:0] ONES  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o, valid_ro, ready_i, flush_i;
    logic [31:0] pc_i, inst_i, r0data_i, r1data_i;
    logic [31:0] pc_ro, inst_ro, r0data_ro, r1data_ro, result_ro;
    logic        busy_o;
    logic [31:0] jumpaddr_o, datamemaddr_o, datamemdata_o;
    logic        jumptaken_o, datamemwrite_o;
    logic [1:0]  datamemwidth_o;

    always #5 clk = ~clk;

    execute_m #(.XLEN(32), .MUL_CYCLES(3), .ENABLE_M(1)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .ready_o(ready_o), .valid_ro(valid_ro), .ready_i(ready_i),
        .flush_i(flush_i), .pc_i(pc_i), .inst_i(inst_i),
        .r0data_i(r0data_i), .r1data_i(r1data_i),
        .pc_ro(pc_ro), .inst_ro(inst_ro), .r0data_ro(r0data_ro), .r1data_ro(r1data_ro),
        .result_ro(result_ro), .busy_o(busy_o),
        .jumpaddr_o(jumpaddr_o), .jumptaken_o(jumptaken_o),
        .datamemaddr_o(datamemaddr_o), .datamemdata_o(datamemdata_o),
        .datamemwrite_o(datamemwrite_o), .datamemwidth_o(datamemwidth_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {imm, 5'd1, f3, 5'd3, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [2:0] f3);
        return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [6:0] op);
        return {imm, 5'd3, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd3, 7'b1101111};
    endfunction

    typedef struct {
        logic [31:0] inst, pc, a, b, res, jaddr, maddr;
        logic        jt, mwr;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] inst, pc, a, b, res, jaddr,
                                input logic jt, input logic [31:0] maddr, input logic mwr);
        vec_t v;
        v.inst = inst; v.pc = pc; v.a = a; v.b = b; v.res = res;
        v.jaddr = jaddr; v.jt = jt; v.maddr = maddr; v.mwr = mwr;
        return v;
    endfunction

    localparam int NV = 22;
    vec_t vecs[NV];

    task automatic run_m(input string name, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        int n;
        int busy;
        inst_i = enc_r(7'b0000001, f3, OP);
        pc_i = 32'h800; r0data_i = a; r1data_i = b; valid_i = 1'b1;
        #1;
        chk({name, "_ready"}, ready_o, 1);
        chk({name, "_jt"}, jumptaken_o, 0);
        tick();
        valid_i = 1'b0;
        n = 0; busy = 0;
        while (!valid_ro && n < 100) begin
            if (busy_o && !ready_o) busy++;
            tick();
            n++;
        end
        chk({name, "_latency"}, n, lat);
        chk({name, "_busycycles"}, busy, lat);
        chk({name, "_result"}, result_ro, exp);
        chk({name, "_pc"}, pc_ro, 32'h800);
        chk({name, "_r0"}, r0data_ro, a);
        chk({name, "_busy_after"}, busy_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
        pc_i = '0; inst_i = '0; r0data_i = '0; r1data_i = '0;

        vecs[0]  = mk(enc_i(12'hFFD, 3'b000, OPIMM), 32'h10, 5, 0, 2, ONES, 0, 0, 0);
        vecs[1]  = mk(enc_i(12'h404, 3'b101, OPIMM), 32'h14, 32'h8000_0000, 0, 32'hF800_0000, ONES, 0, 0, 0);
        vecs[2]  = mk(enc_i(12'h004, 3'b101, OPIMM), 32'h18, 32'h8000_0000, 0, 32'h0800_0000, ONES, 0, 0, 0);
        vecs[3]  = mk(enc_r(7'h00, 3'b000, OP), 32'h1C, 7, 8, 15, ONES, 0, 0, 0);
        vecs[4]  = mk(enc_r(7'h20, 3'b000, OP), 32'h20, 3, 10, 32'hFFFF_FFF9, ONES, 0, 0, 0);
        vecs[5]  = mk(enc_r(7'h00, 3'b010, OP), 32'h24, ONES, 1, 1, ONES, 0, 0, 0);
        vecs[6]  = mk(enc_r(7'h00, 3'b011, OP), 32'h28, ONES, 1, 0, ONES, 0, 0, 0);
        vecs[7]  = mk(enc_r(7'h00, 3'b001, OP), 32'h2C, 1, 32'h25, 32'h20, ONES, 0, 0, 0);
        vecs[8]  = mk(enc_r(7'h20, 3'b101, OP), 32'h30, 32'h8000_0010, 32'h21, 32'hC000_0008, ONES, 0, 0, 0);
        vecs[9]  = mk(enc_r(7'h00, 3'b100, OP), 32'h34, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, ONES, 0, 0, 0);
        vecs[10] = mk(enc_r(7'h00, 3'b111, OP), 32'h38, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, ONES, 0, 0, 0);
        vecs[11] = mk(enc_r(7'h00, 3'b110, OP), 32'h3C, 32'hF0F0_F0F0, 32'h0000_FFFF, 32'hF0F0_FFFF, ONES, 0, 0, 0);
        vecs[12] = mk(enc_u(20'h12345, LUI), 32'h40, 0, 0, 32'h1234_5000, ONES, 0, 0, 0);
        vecs[13] = mk(enc_u(20'h00001, AUIPC), 32'h100, 0, 0, 32'h0000_1100, ONES, 0, 0, 0);
        vecs[14] = mk(enc_j(21'd8), 32'h200, 0, 0, 32'h204, 32'h208, 1, 0, 0);
        vecs[15] = mk(enc_i(12'h004, 3'b000, JALR), 32'h300, 32'h1001, 0, 32'h304, 32'h1004, 1, 0, 0);
        vecs[16] = mk(enc_i(12'hFFC, 3'b010, LOAD), 32'h304, 32'h1000, 0, ONES, ONES, 0, 32'hFFC, 0);
        vecs[17] = mk(enc_s(12'h008, 3'b010), 32'h308, 32'h2000, 32'hDEAD_BEEF, ONES, ONES, 0, 32'h2008, 1);
        vecs[18] = mk(enc_b(13'd16, 3'b001), 32'h400, 1, 2, ONES, 32'h410, 1, 0, 0);
        vecs[19] = mk(enc_b(13'd16, 3'b100), 32'h400, 5, ONES, ONES, 32'h410, 0, 0, 0);
        vecs[20] = mk(enc_b(13'h1FF0, 3'b111), 32'h400, ONES, 1, ONES, 32'h3F0, 1, 0, 0);
        vecs[21] = mk(32'h0000_007F, 32'h500, 1, 2, ONES, ONES, 0, 0, 0);

        // reset state
        #12;
        chk("rst_valid", valid_ro, 0);
        chk("rst_result", result_ro, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", ready_o, 1);
        tick();
        rst = 1'b1;
        tick();

        // single-cycle vector table
        for (int i = 0; i < NV; i++) begin
            inst_i = vecs[i].inst; pc_i = vecs[i].pc;
            r0data_i = vecs[i].a; r1data_i = vecs[i].b; valid_i = 1'b1;
            #1;
            chk($sformatf("v%0d_ready", i), ready_o, 1);
            chk($sformatf("v%0d_jt", i), jumptaken_o, vecs[i].jt);
            chk($sformatf("v%0d_jaddr", i), jumpaddr_o, vecs[i].jaddr);
            chk($sformatf("v%0d_maddr", i), datamemaddr_o, vecs[i].maddr);
            chk($sformatf("v%0d_mwr", i), datamemwrite_o, vecs[i].mwr);
            chk($sformatf("v%0d_mdata", i), datamemdata_o, vecs[i].b);
            chk($sformatf("v%0d_mwidth", i), datamemwidth_o, {30'd0, vecs[i].inst[13:12]});
            tick();
            valid_i = 1'b0;
            chk($sformatf("v%0d_valid", i), valid_ro, 1);
            chk($sformatf("v%0d_result", i), result_ro, vecs[i].res);
            chk($sformatf("v%0d_pc", i), pc_ro, vecs[i].pc);
            chk($sformatf("v%0d_inst", i), inst_ro, vecs[i].inst);
            chk($sformatf("v%0d_r1", i), r1data_ro, vecs[i].b);
        end
        tick();
        chk("drain_valid", valid_ro, 0);

        // multiply (3 MUL cycles) and divide (32 DIV cycles)
        run_m("mulhu", 3'b011, ONES, ONES, 32'hFFFF_FFFE, 4);
        run_m("mul", 3'b000, ONES, ONES, 32'h0000_0001, 4);
        run_m("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4);
        run_m("mulhsu", 3'b010, ONES, ONES, ONES, 4);
        run_m("div", 3'b100, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 33);
        run_m("rem", 3'b110, 32'hFFFF_FFF9, 2, ONES, 33);
        run_m("divu_z", 3'b101, 10, 0, ONES, 33);
        run_m("rem_z", 3'b110, 10, 0, 10, 33);
        run_m("div_ovf", 3'b100, 32'h8000_0000, ONES, 32'h8000_0000, 33);
        run_m("rem_ovf", 3'b110, 32'h8000_0000, ONES, 0, 33);
        run_m("remu", 3'b111, 100, 7, 2, 33);
        run_m("divu", 3'b101, ONES, 16, 32'h0FFF_FFFF, 33);
        tick();

        // backpressure holds the slot; a pending BEQ is taken once the slot frees
        ready_i = 1'b0;
        inst_i = enc_i(12'h001, 3'b000, OPIMM); pc_i = 32'h40; r0data_i = 1; valid_i = 1'b1;
        tick();
        chk("bp_valid", valid_ro, 1);
        chk("bp_result", result_ro, 2);
        inst_i = enc_b(13'd16, 3'b000); pc_i = 32'h500; r0data_i = 5; r1data_i = 5;
        #1;
        chk("bp_ready0", ready_o, 0);
        chk("bp_jt0", jumptaken_o, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_hold%0d_valid", k), valid_ro, 1);
            chk($sformatf("bp_hold%0d_result", k), result_ro, 2);
            chk($sformatf("bp_hold%0d_pc", k), pc_ro, 32'h40);
            chk($sformatf("bp_hold%0d_jt", k), jumptaken_o, 0);
        end
        ready_i = 1'b1;
        #1;
        chk("bp_ready1", ready_o, 1);
        chk("bp_jt1", jumptaken_o, 1);
        chk("bp_jaddr", jumpaddr_o, 32'h510);
        tick();
        valid_i = 1'b0;
        #1;
        chk("bp_jt_once", jumptaken_o, 0);
        chk("bp_beq_valid", valid_ro, 1);
        chk("bp_beq_pc", pc_ro, 32'h500);
        chk("bp_beq_result", result_ro, ONES);

        // flush kills a held output
        ready_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_out_valid", valid_ro, 0);
        ready_i = 1'b1;

        // flush blocks a same-cycle JAL
        inst_i = enc_j(21'd8); pc_i = 32'h600; valid_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("fl_jal_jt", jumptaken_o, 0);
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        chk("fl_jal_valid", valid_ro, 0);

        // flush mid-divide; a store presented while busy is ignored
        inst_i = enc_r(7'b0000001, 3'b100, OP); pc_i = 32'h700; r0data_i = 100; r1data_i = 7;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (9) tick();
        inst_i = enc_s(12'h010, 3'b010); r0data_i = 32'h3000; valid_i = 1'b1;
        #1;
        chk("fl_div_busy", busy_o, 1);
        chk("fl_div_ready", ready_o, 0);
        chk("fl_div_mwr", datamemwrite_o, 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        chk("fl_div_busy_after", busy_o, 0);
        chk("fl_div_valid_after", valid_ro, 0);
        begin
            int seen = 0;
            for (int k = 0; k < 30; k++) begin
                if (valid_ro || busy_o) seen++;
                tick();
            end
            chk("fl_div_no_output", seen, 0);
        end
        inst_i = enc_r(7'h00, 3'b000, OP); pc_i = 32'h704; r0data_i = 20; r1data_i = 22;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk("fl_add_valid", valid_ro, 1);
        chk("fl_add_result", result_ro, 42);
        tick();

        // reset in the middle of a multiply
        inst_i = enc_r(7'b0000001, 3'b000, OP); pc_i = 32'h900; r0data_i = 3; r1data_i = 4;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rs_valid", valid_ro, 0);
        chk("rs_busy", busy_o, 0);
        chk("rs_result", result_ro, 0);
        chk("rs_pc", pc_ro, 0);
        chk("rs_inst", inst_ro, 0);
        tick();
        rst = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 6; k++) begin
                if (valid_ro || busy_o) seen++;
                tick();
            end
            chk("rs_no_output", seen, 0);
        end
        run_m("mul_after_rst", 3'b000, 3, 4, 12, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
